// File: rtl/emulib_rammodel_decoder_b_fifo_pkg.sv
// Shared rammodel header for the B-channel codec pair.
// Holds the bit positions of the 32-bit encoded B word, used by this decoder
// and by the matching encoder. It also holds small field-extraction helpers.
package emulib_rammodel_decoder_b_fifo_pkg;

    localparam int DATA_W    = 32;
    localparam int BID_LSB   = 16;
    localparam int BID_MSB   = 31;
    localparam int BRESP_LSB = 0;
    localparam int BRESP_MSB = 1;

    // Extract the BRESP field from an encoded B word.
    function automatic logic [1:0] get_bresp(input logic [DATA_W-1:0] word);
        return word[BRESP_MSB:BRESP_LSB];
    endfunction

endpackage

// File: rtl/emulib_rammodel_decoder_b_fifo_if.sv
// Bus bundle for the B-channel decoder.
// It carries the encoded-word input handshake (data_valid/data_ready/data) and
// the AXI4 B master channel (axi_bvalid/axi_bready/axi_bid/axi_bresp).
//   master : the decoder side (it drives data_ready and the axi_b* outputs)
//   slave  : the environment side (it drives data_valid, data and axi_bready)
interface emulib_rammodel_decoder_b_fifo_if
    import emulib_rammodel_decoder_b_fifo_pkg::*;
#(
    parameter int ID_WIDTH = 4
);
    logic                data_valid;
    logic                data_ready;
    logic [DATA_W-1:0]   data;
    logic                axi_bvalid;
    logic                axi_bready;
    logic [ID_WIDTH-1:0] axi_bid;
    logic [1:0]          axi_bresp;

    modport master (
        input  data_valid, data, axi_bready,
        output data_ready, axi_bvalid, axi_bid, axi_bresp
    );

    modport slave (
        output data_valid, data, axi_bready,
        input  data_ready, axi_bvalid, axi_bid, axi_bresp
    );
endinterface

// File: rtl/emulib_rammodel_bfifo.sv
// Generic synchronous FIFO. It is reusable for any rammodel response channel.
// The head entry is read from the storage array, so pop_data comes only from
// flops and has no path from push_data. Pushes are ignored when full, and pops
// are ignored when empty.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   push, push_data   write request and write word
//   pop, pop_data     read request and current head word
//   full, empty       occupancy flags
//   count             occupancy, 0..DEPTH
module emulib_rammodel_bfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == CNT_W'(0));
    assign count     = count_r;
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r];

    // Next occupancy. A simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and occupancy registers. DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Storage array. It is deliberately not reset, because contents are only observed while non-empty.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/emulib_rammodel_decoder_b_fifo.sv
// B-channel decoder for the rammodel.
// It accepts encoded 32-bit B words and replays them, in strict FIFO order, as
// AXI4 write responses.
// The word carries BID in [31:16] (only the low ID_WIDTH bits are kept) and
// BRESP in [1:0]. Bits [15:2] are ignored.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   bus        master side of the decoder interface (encoded input + AXI B out)
//   count      queue occupancy, 0..DEPTH
//   idle       high while the queue is empty
// data_ready depends only on occupancy, so axi_bready has no combinational
// path to it. When the queue is full, a same-cycle pop does not make room for
// a push.
module emulib_rammodel_decoder_b_fifo
    import emulib_rammodel_decoder_b_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    emulib_rammodel_decoder_b_fifo_if.master bus,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           idle
);
    localparam int ENTRY_W = ID_WIDTH + 2;
    localparam bit CFG_OK  = (ADDR_WIDTH > 0) && (DATA_WIDTH > 0) &&
                             (ID_WIDTH >= 1) && (ID_WIDTH <= BID_MSB - BID_LSB + 1) &&
                             (DEPTH >= 2) && (DEPTH <= 64) &&
                             ((DEPTH & (DEPTH - 1)) == 0);

    logic [ENTRY_W-1:0] push_entry_s;
    logic [ENTRY_W-1:0] head_entry_s;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               empty_s;
    logic               data_unused_s;

    // Reject illegal configurations at elaboration.
    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("emulib_rammodel_decoder_b_fifo: illegal parameter set");
        end
    endgenerate

    // Queue entry = {BID, BRESP}. The upper BID bits and [15:2] are dropped.
    assign push_entry_s  = {bus.data[BID_LSB +: ID_WIDTH], get_bresp(bus.data)};
    // Whole-word reduction, so that the deliberately ignored bits count as consumed.
    assign data_unused_s = ^bus.data;

    assign push_s = bus.data_valid && !full_s;
    assign pop_s  = bus.axi_bready && !empty_s;

    emulib_rammodel_bfifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_bfifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .pop_data  (head_entry_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count)
    );

    assign bus.data_ready = !full_s;
    assign bus.axi_bvalid = !empty_s;
    assign bus.axi_bid    = head_entry_s[ENTRY_W-1:2];
    assign bus.axi_bresp  = head_entry_s[1:0];
    assign idle           = empty_s;

endmodule

// File: tb/tb_emulib_rammodel_decoder_b_fifo.sv
// Self-checking bench for emulib_rammodel_decoder_b_fifo (DEPTH=4, ID_WIDTH=4).
// A negedge monitor keeps a scoreboard queue. It pushes {BID, BRESP} derived
// from each accepted encoded word, and pops and compares on every B handshake.
// It also checks the occupancy and flags against the scoreboard size. The
// directed steps in the main initial block add point checks for the scenarios
// below.
module tb_emulib_rammodel_decoder_b_fifo;
    localparam int ID_W  = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [2:0] count;
    logic       idle;

    int checks = 0;
    int errors = 0;
    int n_resp = 0;
    logic [ID_W+1:0] sb[$];

    emulib_rammodel_decoder_b_fifo_if #(.ID_WIDTH(ID_W)) bus ();

    emulib_rammodel_decoder_b_fifo #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (64),
        .ID_WIDTH   (ID_W),
        .DEPTH      (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .count (count),
        .idle  (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.axi_bready = 1'b1;
        for (int i = 0; i < 50 && !idle; i++) step();
        check("drain_idle", 32'(idle), 32'd1);
    endtask

    // Scoreboard monitor: it samples mid-cycle what the next rising edge will do.
    always @(negedge clk) begin
        if (!rst) begin
            check("mon_count", 32'(count), 32'(sb.size()));
            check("mon_idle", 32'(idle), 32'(sb.size() == 0));
            check("mon_bvalid", 32'(bus.axi_bvalid), 32'(sb.size() != 0));
            check("mon_ready", 32'(bus.data_ready), 32'(sb.size() != DEPTH));
            if (bus.axi_bvalid && bus.axi_bready && sb.size() != 0) begin
                logic [ID_W+1:0] exp;
                exp = sb.pop_front();
                check("sb_bid", 32'(bus.axi_bid), 32'(exp[ID_W+1:2]));
                check("sb_bresp", 32'(bus.axi_bresp), 32'(exp[1:0]));
                n_resp++;
            end
            if (bus.data_valid && bus.data_ready) begin
                sb.push_back({bus.data[16 +: ID_W], bus.data[1:0]});
            end
        end
    end

    initial begin
        int n0;
        bit acc;
        logic [31:0] w;

        rst = 1'b1;
        bus.data_valid = 1'b0;
        bus.data = 32'h0;
        bus.axi_bready = 1'b0;
        step();
        step();
        check("rst_count", 32'(count), 32'd0);
        check("rst_ready", 32'(bus.data_ready), 32'd1);
        check("rst_bvalid", 32'(bus.axi_bvalid), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        rst = 1'b0;
        step();

        // Single response with one-cycle latency.
        bus.axi_bready = 1'b1;
        bus.data_valid = 1'b1;
        bus.data = 32'h0003_0002;
        step();
        bus.data_valid = 1'b0;
        check("single_bvalid", 32'(bus.axi_bvalid), 32'd1);
        check("single_bid", 32'(bus.axi_bid), 32'd3);
        check("single_bresp", 32'(bus.axi_bresp), 32'd2);
        step();
        check("single_idle", 32'(idle), 32'd1);

        // Fill to DEPTH with the sink stalled, then hold a fifth word.
        bus.axi_bready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.data_valid = 1'b1;
            bus.data = {16'(i), 14'h0, 2'(i)};
            step();
        end
        check("fill_count", 32'(count), 32'd4);
        check("fill_ready", 32'(bus.data_ready), 32'd0);
        bus.data = 32'h0005_0001;
        step();
        check("held_count", 32'(count), 32'd4);
        check("held_ready", 32'(bus.data_ready), 32'd0);

        // Full with a simultaneous pop: pop only, then the push goes in next cycle.
        bus.axi_bready = 1'b1;
        step();
        check("fullpop_count", 32'(count), 32'd3);
        check("fullpop_ready", 32'(bus.data_ready), 32'd1);
        step();
        check("pushpop_count", 32'(count), 32'd3);
        bus.data_valid = 1'b0;
        drain();

        // Backpressure: the head must not change while it is stalled. Ignored bits are set to junk.
        bus.axi_bready = 1'b0;
        bus.data_valid = 1'b1;
        bus.data = 32'hABC9_FFFF;
        step();
        bus.data_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_bvalid", 32'(bus.axi_bvalid), 32'd1);
            check("stall_bid", 32'(bus.axi_bid), 32'd9);
            check("stall_bresp", 32'(bus.axi_bresp), 32'd3);
            step();
        end
        drain();

        // Wrap: 20 words with random sink readiness.
        n0 = n_resp;
        for (int i = 0; i < 20; i++) begin
            bus.data_valid = 1'b1;
            bus.data = {16'(i), 14'(i * 7), 2'(i)};
            acc = 1'b0;
            for (int t = 0; t < 100 && !acc; t++) begin
                bus.axi_bready = 1'($urandom_range(0, 1));
                acc = bus.data_ready;
                step();
            end
            check("wrap_push_accepted", 32'(acc), 32'd1);
        end
        bus.data_valid = 1'b0;
        drain();
        check("wrap_resp_count", 32'(n_resp - n0), 32'd20);

        // Reset in mid-operation, asserted between edges.
        bus.axi_bready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.data_valid = 1'b1;
            bus.data = {16'(i + 10), 16'h0000};
            step();
        end
        bus.data_valid = 1'b0;
        check("pre_rst_count", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("async_rst_bvalid", 32'(bus.axi_bvalid), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_ready", 32'(bus.data_ready), 32'd1);
        check("async_rst_idle", 32'(idle), 32'd1);
        step();
        rst = 1'b0;
        step();
        bus.axi_bready = 1'b1;
        bus.data_valid = 1'b1;
        w = 32'h0007_0001;
        bus.data = w;
        step();
        bus.data_valid = 1'b0;
        check("post_rst_bvalid", 32'(bus.axi_bvalid), 32'd1);
        check("post_rst_bid", 32'(bus.axi_bid), 32'd7);
        check("post_rst_bresp", 32'(bus.axi_bresp), 32'd1);
        step();
        check("post_rst_idle", 32'(idle), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/emulib_rammodel_decoder_b_fifo.md
EMULIB_RAMMODEL_DECODER_B_FIFO -- requirements
Module: emulib_rammodel_decoder_b_fifo

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI address width; passed through only, no internal use.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: AXI data width; passed through only.
REQ-003 SHALL have parameter ID_WIDTH, default 4: BID width; legal range 1..16.
REQ-004 SHALL have parameter DEPTH, default 4: response queue entries; power of two, legal range 2..64.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port data_valid, input, 1: encoded B word valid.
REQ-008 SHALL have port data_ready, output, 1: encoded B word accepted.
REQ-009 SHALL have port data, input, 32: encoded B word; [31:16] = BID, [1:0] = BRESP, [15:2] ignored.
REQ-010 SHALL have the AXI4 custom B master channel axi_* (axi_bvalid out, axi_bready in, axi_bid out ID_WIDTH, axi_bresp out 2).
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1: current queue occupancy.
REQ-012 SHALL have port idle, output, 1: high when the queue is empty.

Function
REQ-013 SHALL push {data[ID_WIDTH+15:16], data[1:0]} into the queue on data fire (data_valid && data_ready).
REQ-014 SHALL drive data_ready = (count != DEPTH); no combinational path from axi_bready to data_ready.
REQ-015 SHALL drive axi_bvalid = (count != 0); axi_bid/axi_bresp = head entry, registered, no combinational path from data.
REQ-016 SHALL pop the head on axi fire (axi_bvalid && axi_bready).
REQ-017 SHALL give latency exactly 1 cycle: a word accepted at edge N into an empty queue appears on axi_bvalid after edge N.
REQ-018 SHALL hold axi_bid/axi_bresp stable while axi_bvalid && !axi_bready (AXI stability rule).
REQ-019 SHALL preserve strict FIFO order; no reordering by ID.
REQ-020 SHALL, on simultaneous push and pop when 0 < count < DEPTH, leave count unchanged and accept both.
REQ-021 SHALL, when count == DEPTH, refuse push (data_ready low) even if a pop occurs the same cycle; data_ready rises the following cycle.
REQ-022 SHALL, when count == 0, not pop; a push in that cycle makes count 1 next cycle.
REQ-023 SHALL wrap read/write pointers modulo DEPTH without gaps or loss.
REQ-024 SHALL ignore data[31:16+ID_WIDTH] and data[15:2].
REQ-025 SHALL drive idle = (count == 0).

Reset
REQ-026 SHALL, while rst is high, force count = 0, pointers = 0, axi_bvalid = 0, data_ready = 1, idle = 1, asynchronously.
REQ-027 SHALL leave storage array contents unreset; axi_bid/axi_bresp are don't-care while axi_bvalid = 0.
REQ-028 SHALL discard all queued responses on reset asserted mid-operation; first post-reset push behaves as from empty.

Structure
REQ-029 SHALL place the data-word field positions (BID_LSB = 16, BID_MSB = 31, BRESP_LSB = 0, BRESP_MSB = 1) in the shared rammodel header, used by this block and the matching encoder.
REQ-030 SHALL implement the queue as one sub-module emulib_rammodel_bfifo (parametrised WIDTH, DEPTH; push/pop/full/empty/count), reusable for other channels.
REQ-031 SHALL fit in 120-400 lines of RTL in total, with no vendor primitives.

Verification
REQ-032 Single response: DEPTH=4, push data=0x0003_0002, bready=1 -> next cycle bvalid=1, bid=3, bresp=2; then idle=1.
REQ-033 Fill: bready=0, push 4 words with IDs 1..4 -> count=4, data_ready=0; 5th word held; bready=1 -> BIDs 1,2,3,4,5 in order.
REQ-034 Full with simultaneous pop: count=4, data_valid=1, bready=1 -> pop only, count=3; next cycle push accepted, count stays 3.
REQ-035 Backpressure: bvalid=1, bready=0 for 5 cycles -> bid/bresp unchanged all 5 cycles.
REQ-036 Wrap: stream 20 words with IDs 0..19, random bready -> 20 responses, IDs in order mod 2^ID_WIDTH, bresp matches.
REQ-037 Mid-operation reset: count=3, assert rst between edges -> bvalid=0, count=0 immediately; after release push 0x0007_0001 -> bid=7, bresp=1.
